mesh_step_sequencer: RTL and testbench
======================================

# mesh_step_sequencer

Parametrised time-step sequencer and spike I/O engine for the neuromorphic mesh. It sits between the host/test environment and the boundary router's local port, all in the router clock domain. It generates the per-step `start` pulse for the neuron tiles and buffers host spike packets in a FIFO, injecting them into the router only during a configurable window at the start of each step. It also collects packets from NUM_CH boundary channels into a per-step count and a running XOR signature. It replaces the fixed 4-bit, single-channel step controller and adds depth, channel-count and injection-window generalisation.

## Interface
- STEP_NUMBER, 32: time steps per run (>=1)
- STEP_CYCLE, 64: rt_clk cycles per step (>=4)
- INJ_WINDOW, 16: cycles at the start of each step in which injection is allowed (1..STEP_CYCLE)
- PKT_WIDTH, 4: spike packet width in bits
- NUM_CH, 4: boundary receive channels
- FIFO_DEPTH, 8: injection FIFO entries (power of 2, >=2)

- rt_clk  in  1  router clock; the only clock
- rt_reset  in  1  asynchronous, active-high reset
- run  in  1  level; high starts and sustains a run; low aborts or clears done
- host_wr  in  1  push host_pkt into the injection FIFO
- host_pkt  in  PKT_WIDTH  packet to inject
- host_full  out  1  FIFO holds FIFO_DEPTH entries
- spike_packet  out  PKT_WIDTH  FIFO head, valid when write_req=1
- write_req  out  1  write strobe to the router local port
- receive_full  in  1  router local input FIFO full
- packet_in  in  NUM_CH*PKT_WIDTH  boundary packets; channel i is bits [i*PKT_WIDTH +: PKT_WIDTH]
- write_enable  in  NUM_CH  per-channel valid
- start  out  1  one-cycle pulse in the first cycle of every step
- step_idx  out  16  current step, 0-based
- rx_count  out  16  packets received so far in the current step
- rx_last  out  16  rx_count of the last completed step
- signature  out  PKT_WIDTH  running XOR of all received packets
- result_output  out  1  XOR-reduce of signature
- busy  out  1  state==RUN
- done  out  1  state==DONE

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- IDLE, run=1: go to RUN. cycle_cnt, step_idx, signature and rx_count clear to 0.
- RUN, run=0: abort to IDLE. Counters hold. FIFO contents are retained.
- RUN, cycle_cnt==STEP_CYCLE-1:
  - If step_idx==STEP_NUMBER-1, go to DONE.
  - Otherwise step_idx+1 and cycle_cnt=0.
  - In both cases rx_last latches the final rx_count, including arrivals in that cycle.
- DONE, run=0: go to IDLE. done clears.
- start = RUN && cycle_cnt==0. It is driven from registers only.
- FIFO push:
  - Occurs when host_wr && !host_full, in any state.
  - A push while host_full is dropped, even if a pop occurs in the same cycle.
- FIFO pop:
  - write_req = RUN && cycle_cnt<INJ_WINDOW && !empty && !receive_full. This is combinational from registers plus receive_full.
  - The pop occurs on the same edge the router samples write_req.
  - Push and pop in the same cycle leave the count unchanged.
- Receive:
  - Active only in RUN. Arrivals in IDLE and DONE are ignored.
  - signature ^= XOR of packet_in[i] over every i with write_enable[i].
  - rx_count += popcount(write_enable), saturating at 0xFFFF.
  - In a start cycle, rx_count loads that cycle's popcount instead of accumulating.
- Pointers are log2(FIFO_DEPTH) bits and wrap. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: state IDLE, FIFO empty, and all of the following are 0: host_full, write_req, start, step_idx, rx_count, rx_last, signature, result_output, busy, done.
  - spike_packet reflects the storage at the head pointer and is a don't-care while write_req=0.
- run sampled high in IDLE at edge N:
  - busy=1 and start=1 in cycle N+1.
- A full run lasts exactly STEP_NUMBER*STEP_CYCLE RUN cycles, then done=1 in the next cycle.
- Injection latency: a packet pushed at edge N is visible at the head and can be popped at edge N+1 at the earliest.
- receive_full asserted:
  - write_req=0 in the same cycle. The head is held, not lost.
- Injection window closes with packets pending:
  - The packets stay in the FIFO and drain in the next step's window.
- Reset asserted mid-run:
  - Immediate return to reset values. The FIFO is flushed.

## Test plan
- STEP_NUMBER=3, STEP_CYCLE=8, run held high -> start pulses at RUN cycles 0, 8 and 16; step_idx 0→1→2; done=1 at cycle 24; busy=0 from cycle 24.
- FIFO_DEPTH=4, INJ_WINDOW=4, push 6 packets 0x1..0x6 in IDLE -> host_full after the 4th push; 0x5 and 0x6 dropped; in RUN, write_req on step-0 cycles 0..3 with spike_packet 0x1, 0x2, 0x3, 0x4.
- Push 0xA, 0xB; receive_full=1 on cycles 0..1 of a step -> write_req=0 while full; 0xA on cycle 2, 0xB on cycle 3.
- INJ_WINDOW=2, 5 packets queued -> 2 injected per step over steps 0, 1, 2; no write_req at cycle_cnt>=2.
- NUM_CH=4, write_enable=4'b1111 with packets 0x1, 0x2, 0x4, 0x8 in one RUN cycle -> rx_count+4, signature=0xF, result_output=0; rx_last at step end equals the step total.
- Assert rt_reset mid-step 1 with 2 packets queued -> all outputs 0 and FIFO empty immediately; run high after release restarts at step 0 with start=1.

Source files
------------

// File: rtl/mesh_step_sequencer_if.sv
// Host/router/boundary signal bundle for the mesh step sequencer.
interface mesh_step_sequencer_if #(
  parameter int unsigned PKT_WIDTH = 4,
  parameter int unsigned NUM_CH    = 4
);
  logic                        run;
  logic                        host_wr;
  logic [PKT_WIDTH-1:0]        host_pkt;
  logic                        host_full;
  logic [PKT_WIDTH-1:0]        spike_packet;
  logic                        write_req;
  logic                        receive_full;
  logic [NUM_CH*PKT_WIDTH-1:0] packet_in;
  logic [NUM_CH-1:0]           write_enable;
  logic                        start;
  logic [15:0]                 step_idx;
  logic [15:0]                 rx_count;
  logic [15:0]                 rx_last;
  logic [PKT_WIDTH-1:0]        signature;
  logic                        result_output;
  logic                        busy;
  logic                        done;

  modport slave (
    input  run, host_wr, host_pkt, receive_full, packet_in, write_enable,
    output host_full, spike_packet, write_req, start, step_idx, rx_count,
           rx_last, signature, result_output, busy, done
  );

  modport master (
    output run, host_wr, host_pkt, receive_full, packet_in, write_enable,
    input  host_full, spike_packet, write_req, start, step_idx, rx_count,
           rx_last, signature, result_output, busy, done
  );
endinterface

// File: rtl/mesh_step_sequencer.sv
// Time-step sequencer with windowed spike injection FIFO and per-step receive
// counting/XOR signature for the neuromorphic mesh boundary router.
module mesh_step_sequencer #(
  parameter int unsigned STEP_NUMBER = 32,
  parameter int unsigned STEP_CYCLE  = 64,
  parameter int unsigned INJ_WINDOW  = 16,
  parameter int unsigned PKT_WIDTH   = 4,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic                  rt_clk,
  input logic                  rt_reset,
  mesh_step_sequencer_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(STEP_CYCLE);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned PC_W   = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cycle_cnt;
  logic [15:0]          step_idx;
  logic [15:0]          rx_count;
  logic [15:0]          rx_last;
  logic [PKT_WIDTH-1:0] signature;
  logic                 result_output;
  logic                 start;
  logic                 busy;
  logic                 done;

  logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [FCNT_W-1:0]    fifo_cnt;
  logic [FCNT_W-1:0]    fifo_cnt_next;
  logic                 host_full;

  logic                 empty_c;
  logic                 in_window_c;
  logic                 write_req_c;
  logic                 push_c;
  logic                 step_end_c;
  logic                 last_step_c;

  logic [PC_W-1:0]      rx_pop_c;
  logic [PKT_WIDTH-1:0] rx_xor_c;
  logic [16:0]          rx_sum_c;
  logic [15:0]          rx_next_c;
  logic [PKT_WIDTH-1:0] sig_next_c;

  assign empty_c     = (fifo_cnt == '0);
  assign in_window_c = (32'(cycle_cnt) < INJ_WINDOW);
  assign write_req_c = (state == RUN) && in_window_c && !empty_c && !bus.receive_full;
  assign push_c      = bus.host_wr && !host_full;
  assign step_end_c  = (cycle_cnt == CNT_W'(STEP_CYCLE - 1));
  assign last_step_c = (step_idx == 16'(STEP_NUMBER - 1));

  // Popcount and XOR of this cycle's valid boundary packets
  always_comb begin
    rx_pop_c = '0;
    rx_xor_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.write_enable[i]) begin
        rx_pop_c = rx_pop_c + PC_W'(1);
        rx_xor_c = rx_xor_c ^ bus.packet_in[i*PKT_WIDTH +: PKT_WIDTH];
      end
    end
  end

  // A start cycle restarts the per-step count; otherwise saturate at 0xFFFF
  always_comb begin
    rx_sum_c   = 17'(rx_count) + 17'(rx_pop_c);
    sig_next_c = signature ^ rx_xor_c;
    if (start) begin
      rx_next_c = 16'(rx_pop_c);
    end else if (rx_sum_c[16]) begin
      rx_next_c = 16'hFFFF;
    end else begin
      rx_next_c = rx_sum_c[15:0];
    end
  end

  // Step sequencing FSM with registered status outputs
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      step_idx      <= '0;
      rx_count      <= '0;
      rx_last       <= '0;
      signature     <= '0;
      result_output <= 1'b0;
      start         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state         <= RUN;
            cycle_cnt     <= '0;
            step_idx      <= '0;
            rx_count      <= '0;
            signature     <= '0;
            result_output <= 1'b0;
            start         <= 1'b1;
            busy          <= 1'b1;
          end
        end
        RUN: begin
          signature     <= sig_next_c;
          result_output <= ^sig_next_c;
          rx_count      <= rx_next_c;
          if (!bus.run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_end_c) begin
            rx_last <= rx_next_c;
            if (last_step_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step_idx  <= step_idx + 16'd1;
              cycle_cnt <= '0;
              start     <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!bus.run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push while full is dropped regardless of a same-cycle pop
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (push_c && !write_req_c) begin
      fifo_cnt_next = fifo_cnt + FCNT_W'(1);
    end else if (!push_c && write_req_c) begin
      fifo_cnt_next = fifo_cnt - FCNT_W'(1);
    end
  end

  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      host_full <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (write_req_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt  <= fifo_cnt_next;
      host_full <= (fifo_cnt_next == FCNT_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge rt_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.host_pkt;
    end
  end

  assign bus.host_full     = host_full;
  assign bus.spike_packet  = mem[rd_ptr];
  assign bus.write_req     = write_req_c;
  assign bus.start         = start;
  assign bus.step_idx      = step_idx;
  assign bus.rx_count      = rx_count;
  assign bus.rx_last       = rx_last;
  assign bus.signature     = signature;
  assign bus.result_output = result_output;
  assign bus.busy          = busy;
  assign bus.done          = done;

endmodule

// File: tb/tb_mesh_step_sequencer.sv
// Directed bench for mesh_step_sequencer: an elapsed-time/queue model checked
// every cycle, plus literal expectations at the interesting points.
module tb_mesh_step_sequencer;

  localparam int SN    = 3;
  localparam int SC    = 8;
  localparam int IW    = 2;
  localparam int PW    = 4;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic rt_clk = 1'b0;
  logic rt_reset;
  always #5 rt_clk = ~rt_clk;

  mesh_step_sequencer_if #(.PKT_WIDTH(PW), .NUM_CH(NCH)) bus ();

  mesh_step_sequencer #(
    .STEP_NUMBER(SN), .STEP_CYCLE(SC), .INJ_WINDOW(IW),
    .PKT_WIDTH(PW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .rt_clk  (rt_clk),
    .rt_reset(rt_reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // mode: 0 idle, 1 run, 2 done; t counts RUN cycles since the run began
  int           m_mode;
  int           m_t;
  logic [PW-1:0] m_q[$];
  logic [PW-1:0] m_sig;
  int           m_rx;
  int           m_rx_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_wr();
    return (m_mode == 1) && ((m_t % SC) < IW) && (m_q.size() > 0) && !bus.receive_full;
  endfunction

  always @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      m_mode = 0; m_t = 0; m_q.delete(); m_sig = '0; m_rx = 0; m_rx_last = 0;
    end else begin
      logic pop_now;
      logic push_now;
      int   pc;
      logic [PW-1:0] x;
      pop_now  = exp_wr();
      push_now = bus.host_wr && (m_q.size() < DEPTH);
      if (pop_now) void'(m_q.pop_front());
      if (push_now) m_q.push_back(bus.host_pkt);
      case (m_mode)
        0: if (bus.run) begin m_mode = 1; m_t = 0; m_sig = '0; m_rx = 0; end
        1: begin
          pc = 0; x = '0;
          for (int i = 0; i < NCH; i++) begin
            if (bus.write_enable[i]) begin
              pc++;
              x = x ^ bus.packet_in[i*PW +: PW];
            end
          end
          m_sig = m_sig ^ x;
          if ((m_t % SC) == 0) m_rx = pc;
          else m_rx = (m_rx + pc > 65535) ? 65535 : m_rx + pc;
          if (!bus.run) m_mode = 0;
          else if ((m_t % SC) == SC - 1) begin
            m_rx_last = m_rx;
            if (m_t == SN*SC - 1) m_mode = 2;
            else m_t++;
          end else m_t++;
        end
        default: if (!bus.run) m_mode = 0;
      endcase
    end
  end

  always @(negedge rt_clk) begin
    logic wr;
    wr = exp_wr();
    chk("busy",      32'(bus.busy),          32'(m_mode == 1));
    chk("done",      32'(bus.done),          32'(m_mode == 2));
    chk("start",     32'(bus.start),         32'(m_mode == 1 && (m_t % SC) == 0));
    chk("step_idx",  32'(bus.step_idx),      32'(m_t / SC));
    chk("write_req", 32'(bus.write_req),     32'(wr));
    if (wr) chk("spike_packet", 32'(bus.spike_packet), 32'(m_q[0]));
    chk("host_full", 32'(bus.host_full),     32'(m_q.size() == DEPTH));
    chk("rx_count",  32'(bus.rx_count),      32'(m_rx));
    chk("rx_last",   32'(bus.rx_last),       32'(m_rx_last));
    chk("signature", 32'(bus.signature),     32'(m_sig));
    chk("result",    32'(bus.result_output), 32'(^m_sig));
  end

  task automatic cyc();
    @(posedge rt_clk);
    #1;
  endtask

  initial begin
    rt_reset = 1'b1;
    bus.run = 1'b0; bus.host_wr = 1'b0; bus.host_pkt = '0;
    bus.receive_full = 1'b0; bus.packet_in = '0; bus.write_enable = '0;
    cyc(); cyc();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.host_full), 32'd0);
    chk("rst_step", 32'(bus.step_idx), 32'd0);
    cyc();
    rt_reset = 1'b0;
    cyc();

    // Six pushes into a depth-4 FIFO: the last two are dropped
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k == 4) chk("full_before4", 32'(bus.host_full), 32'd0);
      if (k == 5) chk("full_after4", 32'(bus.host_full), 32'd1);
      bus.host_wr = 1'b1; bus.host_pkt = 4'(k);
      cyc();
    end
    bus.host_wr = 1'b0;

    // Full run with injection and receive activity
    bus.run = 1'b1;
    cyc();
    for (int k = 0; k < SN*SC; k++) begin
      bus.write_enable = (k == 3) ? 4'hF : ((k == 10) ? 4'b0101 : 4'h0);
      bus.packet_in    = (k == 3) ? 16'h8421 : ((k == 10) ? 16'h0403 : 16'h0000);
      #1;
      case (k)
        0:  begin chk("r1_start0", 32'(bus.start), 32'd1); chk("r1_pkt0", 32'(bus.spike_packet), 32'h1); end
        1:  chk("r1_pkt1", 32'(bus.spike_packet), 32'h2);
        2:  chk("r1_win_closed", 32'(bus.write_req), 32'd0);
        4:  begin chk("r1_rx4", 32'(bus.rx_count), 32'd4); chk("r1_sigF", 32'(bus.signature), 32'hF);
                  chk("r1_res0", 32'(bus.result_output), 32'd0); end
        8:  begin chk("r1_start8", 32'(bus.start), 32'd1); chk("r1_step1", 32'(bus.step_idx), 32'd1);
                  chk("r1_last4", 32'(bus.rx_last), 32'd4); chk("r1_pkt3", 32'(bus.spike_packet), 32'h3); end
        9:  chk("r1_pkt4", 32'(bus.spike_packet), 32'h4);
        11: begin chk("r1_rx2", 32'(bus.rx_count), 32'd2); chk("r1_sig8", 32'(bus.signature), 32'h8);
                  chk("r1_res1", 32'(bus.result_output), 32'd1); end
        16: begin chk("r1_start16", 32'(bus.start), 32'd1); chk("r1_step2", 32'(bus.step_idx), 32'd2);
                  chk("r1_last2", 32'(bus.rx_last), 32'd2); end
        default: ;
      endcase
      cyc();
    end
    #1;
    chk("r1_done", 32'(bus.done), 32'd1);
    chk("r1_busy_off", 32'(bus.busy), 32'd0);
    chk("r1_last0", 32'(bus.rx_last), 32'd0);

    // receive_full holds the head
    bus.run = 1'b0;
    cyc();
    bus.host_wr = 1'b1; bus.host_pkt = 4'hA; cyc();
    bus.host_pkt = 4'hB; cyc();
    bus.host_wr = 1'b0; bus.receive_full = 1'b1; bus.run = 1'b1;
    cyc();
    for (int k = 0; k < 2*SC; k++) begin
      bus.receive_full = (k == 0);
      #1;
      case (k)
        0: chk("rf_blocked", 32'(bus.write_req), 32'd0);
        1: begin chk("rf_wr", 32'(bus.write_req), 32'd1); chk("rf_pktA", 32'(bus.spike_packet), 32'hA); end
        2: chk("rf_pending", 32'(bus.write_req), 32'd0);
        8: chk("rf_pktB", 32'(bus.spike_packet), 32'hB);
        9: chk("rf_empty", 32'(bus.write_req), 32'd0);
        default: ;
      endcase
      cyc();
    end
    // Abort: counters hold in IDLE
    bus.run = 1'b0;
    cyc();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_step_hold", 32'(bus.step_idx), 32'd2);
    cyc();

    // Five packets through a two-cycle window, full-drop on simultaneous pop
    for (int k = 5; k <= 8; k++) begin
      bus.host_wr = 1'b1; bus.host_pkt = 4'(k); cyc();
    end
    bus.host_wr = 1'b0; bus.run = 1'b1;
    cyc();
    for (int k = 0; k < SN*SC; k++) begin
      bus.host_wr  = (k == 0 || k == 1);
      bus.host_pkt = (k == 0) ? 4'hE : 4'h9;
      #1;
      case (k)
        0:  begin chk("w_full", 32'(bus.host_full), 32'd1); chk("w_pkt5", 32'(bus.spike_packet), 32'h5); end
        1:  begin chk("w_drop_full", 32'(bus.host_full), 32'd0); chk("w_pkt6", 32'(bus.spike_packet), 32'h6); end
        8:  chk("w_pkt7", 32'(bus.spike_packet), 32'h7);
        16: chk("w_pkt9", 32'(bus.spike_packet), 32'h9);
        17: chk("w_drained", 32'(bus.write_req), 32'd0);
        default: ;
      endcase
      cyc();
    end
    bus.host_wr = 1'b0; bus.run = 1'b0;
    cyc();

    // Reset mid-step 1 with two packets queued
    bus.run = 1'b1;
    cyc();
    for (int k = 0; k < 11; k++) begin
      bus.host_wr      = (k == 4 || k == 5);
      bus.host_pkt     = (k == 4) ? 4'hC : 4'hD;
      bus.receive_full = (k >= 8);
      cyc();
    end
    bus.host_wr = 1'b0; bus.receive_full = 1'b0;
    rt_reset = 1'b1;
    #1;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_step", 32'(bus.step_idx), 32'd0);
    chk("mr_wr", 32'(bus.write_req), 32'd0);
    chk("mr_sig", 32'(bus.signature), 32'd0);
    cyc();
    rt_reset = 1'b0;
    cyc();
    #1;
    chk("mr_restart", 32'(bus.start), 32'd1);
    chk("mr_restart_step", 32'(bus.step_idx), 32'd0);
    chk("mr_flushed", 32'(bus.write_req), 32'd0);
    cyc(); cyc();
    bus.run = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
